// File: rtl/cfg_frame_tx.sv
//==============================================================================
// Module      : cfg_frame_tx
// Description : Word FIFO plus a framing FSM.  The FSM sends a host-selected
//               number of queued words to a serial-load block.  The frame is
//               marked by an active-low select (ssb) and ends with a one-cycle
//               done pulse.  Optional feature macro: CFG_FRAME_TX_CHECKSUM_EN
//               adds a trailing XOR checksum word to every frame.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cfg_frame_tx #(
  parameter int DW    = 23,
  parameter int DEPTH = 16
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          start,
  input  logic [4:0]    frame_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          ssb,
  output logic [DW-1:0] sdi
);

  localparam int            AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW         = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] c_ptr_last = AW'(DEPTH - 1);
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);

`ifdef CFG_FRAME_TX_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SEND  = 3'd2,
    S_HOLD  = 3'd3,
    S_CHK   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SEND  = 3'd2,
    S_HOLD  = 3'd3
  } state_e;
`endif

  // Storage and pointers
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Frame control; len_q counts the words still to be popped
  state_e        state_q, state_d;
  logic [4:0]    len_q, len_d;

  // Registered outputs
  logic          wr_ready_q, wr_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ssb_q, ssb_d;
  logic [DW-1:0] sdi_q, sdi_d;

`ifdef CFG_FRAME_TX_CHECKSUM_EN
  logic [DW-1:0] acc_q, acc_d;
`endif

  logic          wr_fire;
  logic          pop;
  logic          start_ok;

  assign wr_fire = wr_valid & wr_ready_q;

  // A start is legal only for a non-zero length that fits the FIFO and is already queued
  assign start_ok = (frame_len != 5'd0)
                 && (32'(frame_len) <= DEPTH)
                 && (32'(frame_len) <= 32'(count_q));

  // Frame FSM next state, word pop decision and next output values
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pop     = 1'b0;
    err_d   = 1'b0;
    sdi_d   = '0;
`ifdef CFG_FRAME_TX_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d = S_SETUP;
            len_d   = frame_len;
`ifdef CFG_FRAME_TX_CHECKSUM_EN
            acc_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        // First word is popped on the edge that enters SEND
        state_d = S_SEND;
        pop     = 1'b1;
        len_d   = len_q - 5'd1;
      end
      S_SEND: begin
        if (len_q == 5'd0) begin
`ifdef CFG_FRAME_TX_CHECKSUM_EN
          state_d = S_CHK;
          sdi_d   = acc_q;
`else
          state_d = S_HOLD;
`endif
        end else begin
          pop   = 1'b1;
          len_d = len_q - 5'd1;
        end
      end
`ifdef CFG_FRAME_TX_CHECKSUM_EN
      S_CHK: begin
        state_d = S_HOLD;
      end
`endif
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      sdi_d = mem_q[rd_ptr_q];
`ifdef CFG_FRAME_TX_CHECKSUM_EN
      acc_d = acc_q ^ mem_q[rd_ptr_q];
`endif
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state
  always_comb begin
    ssb_d  = (state_d == S_IDLE) || (state_d == S_HOLD);
    done_d = (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
  end

  // FIFO pointer and occupancy update; a write and a pop together leave the count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({wr_fire, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    wr_ready_d = (count_d != c_depth);
  end

  // State, FIFO control and output registers; reset aborts any frame immediately
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ssb_q      <= 1'b1;
      sdi_q      <= '0;
`ifdef CFG_FRAME_TX_CHECKSUM_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ssb_q      <= ssb_d;
      sdi_q      <= sdi_d;
`ifdef CFG_FRAME_TX_CHECKSUM_EN
      acc_q      <= acc_d;
`endif
    end
  end

  // Word storage; contents are don't-care until written, so it carries no reset
  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ssb      = ssb_q;
  assign sdi      = sdi_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_frame_tx.sv
//==============================================================================
// Module      : tb_cfg_frame_tx
// Description : Scoreboard bench for cfg_frame_tx.  A queue-based reference
//               model predicts every frame word, done and err pulse with its
//               cycle; a negedge monitor pops and compares what the DUT shows.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cfg_frame_tx;

  localparam int DW    = 23;
  localparam int DEPTH = 16;
`ifdef CFG_FRAME_TX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int K_SDI  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int            kind;
    logic [DW-1:0] val;
    int            cyc;
  } item_t;

  logic          CLK = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [4:0]    frame_len = '0;
  logic          wr_ready, busy, done, err, ssb;
  logic [DW-1:0] sdi;

  cfg_frame_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .start    (start),
    .frame_len(frame_len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ssb      (ssb),
    .sdi      (sdi)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model state
  logic [DW-1:0] mq[$];
  item_t         exp_q[$];
  bit            active = 1'b0;
  int            t_frm = 0;
  int            n_len = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input logic [DW-1:0] val, input int c);
    item_t it;
    it.kind = kind;
    it.val  = val;
    it.cyc  = c;
    exp_q.push_back(it);
  endtask

  task automatic mon_item(input int kind, input logic [DW-1:0] val);
    item_t it;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: got kind=%0d val=0x%0h cyc=%0d, want no output", kind, val, cyc);
    end else begin
      it = exp_q.pop_front();
      if (it.kind != kind || it.val !== val || it.cyc != cyc) begin
        n_bad++;
        $display("FAIL scoreboard: got kind=%0d val=0x%0h cyc=%0d, want kind=%0d val=0x%0h cyc=%0d",
                 kind, val, cyc, it.kind, it.val, it.cyc);
      end
    end
  endtask

  // Monitor: every visible frame word, done and err pulse must match the next prediction
  always @(negedge CLK) begin
    if (rst) begin
      if (!ssb) mon_item(K_SDI, sdi);
      else      chk("sdi_while_ssb_high", 32'(sdi), 32'd0);
      if (done) mon_item(K_DONE, '0);
      if (err)  mon_item(K_ERR, '0);
    end
  end

  // One clock of stimulus: the model predicts the effect of the current inputs at the next edge
  task automatic step();
    bit acc_w;
    int e;
    acc_w = wr_valid && (mq.size() < DEPTH);
    e     = cyc + 1;
    if (active) begin
      t_frm++;
      if (t_frm <= n_len) void'(mq.pop_front());
      if (t_frm == n_len + 2 + CK) active = 1'b0;
    end else if (start) begin
      if (frame_len >= 5'd1 && int'(frame_len) <= DEPTH && int'(frame_len) <= mq.size()) begin
        logic [DW-1:0] x;
        x = '0;
        n_len = int'(frame_len);
        push_exp(K_SDI, '0, e);
        for (int i = 0; i < n_len; i++) begin
          push_exp(K_SDI, mq[i], e + 1 + i);
          x ^= mq[i];
        end
        if (CK == 1) push_exp(K_SDI, x, e + n_len + 1);
        push_exp(K_DONE, '0, e + n_len + 1 + CK);
        active = 1'b1;
        t_frm  = 0;
      end else begin
        push_exp(K_ERR, '0, e);
      end
    end
    if (acc_w) mq.push_back(wr_data);
    @(posedge CLK);
    #1;
    chk("busy", 32'(busy), 32'(active));
    chk("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
  endtask

  task automatic wr(input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    start    = 1'b0;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic go(input logic [4:0] len);
    start     = 1'b1;
    frame_len = len;
    step();
    start     = 1'b0;
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    start    = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int b;
    b = 0;
    wr_valid = 1'b0;
    start    = 1'b0;
    while (active && b < 100) begin
      step();
      b++;
    end
    chk("drain_timeout", 32'(active), 32'd0);
  endtask

  // Mid-cycle asynchronous reset: outputs must change before any clock edge
  task automatic async_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_ssb", 32'(ssb), 32'd1);
    chk("rst_sdi", 32'(sdi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    mq.delete();
    exp_q.delete();
    active   = 1'b0;
    wr_valid = 1'b0;
    start    = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #3 rst = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge CLK);
    #1;
    chk("por_ssb", 32'(ssb), 32'd1);
    chk("por_sdi", 32'(sdi), 32'd0);
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_done", 32'(done), 32'd0);
    chk("por_err", 32'(err), 32'd0);
    chk("por_wr_ready", 32'(wr_ready), 32'd1);
    #3 rst = 1'b1;
    @(posedge CLK);
    #1;

    // Basic 4-word frame
    for (int i = 1; i <= 4; i++) wr(DW'(i));
    go(5'd4);
    drain();
    idle(1);

    // Too few words queued, then that pair sent as a frame
    wr(DW'($urandom));
    wr(DW'($urandom));
    go(5'd3);
    idle(1);
    go(5'd2);
    drain();

    // Illegal lengths
    wr(DW'($urandom));
    go(5'd0);
    idle(1);
    go(5'd17);
    idle(1);
    go(5'd31);
    idle(1);
    go(5'd1);
    drain();

    // Full FIFO, rejected extra write, full-length frame with write in first SEND cycle
    for (int i = 0; i < 16; i++) wr(DW'($urandom));
    wr(DW'($urandom));
    go(5'd16);
    idle(1);
    wr(DW'($urandom));
    go(5'd1);                 // ignored: frame in progress
    drain();
    go(5'd2);                 // one word left, rejected
    idle(1);
    go(5'd1);
    drain();

    // Reset in the third SEND cycle of an 8-word frame
    for (int i = 0; i < 11; i++) wr(DW'(32'h100 + i));
    go(5'd8);
    idle(3);
    async_reset();
    for (int i = 0; i < 3; i++) wr(DW'(32'hA00 + i));
    go(5'd4);
    idle(1);
    go(5'd3);
    drain();

    // Back-to-back frames, second start the cycle after done
    for (int i = 0; i < 5; i++) wr(DW'($urandom));
    go(5'd2);
    drain();
    go(5'd3);
    drain();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      wr_valid  = ($urandom_range(0, 2) != 0);
      wr_data   = DW'($urandom);
      start     = ($urandom_range(0, 9) == 0);
      frame_len = 5'($urandom_range(0, 18));
      step();
    end
    drain();
    idle(3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
